// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Register map (PrAddr):
//   0 TXDATA  W: push Data_in[7:0] (drop + set OVF when full)   R: 0
//   1 CTRL    {IM, EN}
//   2 DIV     bit period = DIV+1 clk cycles
//   3 STATUS  {count[2:0], OVF, EMPTY, FULL, BUSY}; write bit3=1 clears OVF
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   PrAddr         register select
//   Wr_en          register write strobe
//   Data_in        write data
//   Data_out       read data, combinational from PrAddr
//   IRQ            IM & EMPTY & ~BUSY
//   txd            serial line, idle high
module uart_tx_dev #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PrAddr,
  input  logic        Wr_en,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        IRQ,
  output logic        txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          en, im, ovf;
  logic [15:0]   div, frame_div, baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          empty, full, busy, push, pop, bit_end;
  logic [7:0]    count8;
  logic          unused_bits;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign busy    = (state != IDLE);
  assign push    = Wr_en && (PrAddr == 2'd0) && !full;
  assign bit_end = (baud_cnt == frame_div);
  assign count8  = 8'(count);
  assign unused_bits = ^{Data_in[31:16], count8[7:3]};

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (en && !empty) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- frame datapath ----------------
  // The divisor is captured at pop so DIV writes only affect later frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_div <= '0;
    end else if (pop) begin
      shreg     <= mem[rd_ptr];
      frame_div <= div;
      baud_cnt  <= '0;
      bit_idx   <= '0;
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      default: txd = 1'b1;
    endcase
  end

  // ---------------- FIFO + registers ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      en     <= 1'b0;
      im     <= 1'b0;
      ovf    <= 1'b0;
      div    <= DIV_RESET;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (Wr_en) begin
        case (PrAddr)
          2'd0: if (full) ovf <= 1'b1;
          2'd1: {im, en} <= Data_in[1:0];
          2'd2: div <= Data_in[15:0];
          2'd3: if (Data_in[3]) ovf <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (PrAddr)
      2'd1:    Data_out = {30'b0, im, en};
      2'd2:    Data_out = {16'b0, div};
      2'd3:    Data_out = {25'b0, count8[2:0], ovf, empty, full, busy};
      default: Data_out = 32'b0;
    endcase
  end

  assign IRQ = im & empty & ~busy;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomized bench for uart_tx_dev against a queue-based reference model:
// the FIFO is a byte queue and each frame is pre-expanded into a queue of
// per-cycle txd values consumed one per clock.
module tb_uart_tx_dev;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PrAddr;
  logic        Wr_en;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic        IRQ;
  logic        txd;

  uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd15)) dut (
    .clk(clk), .reset(reset), .PrAddr(PrAddr), .Wr_en(Wr_en),
    .Data_in(Data_in), .Data_out(Data_out), .IRQ(IRQ), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [7:0]  fq[$];
  bit          wave[$];
  bit          m_en, m_im, m_ovf;
  logic [15:0] m_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    return (wave.size() > 0) ? wave[0] : 1'b1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    int  n;
    bit  busy;
    logic [2:0] c;
    n    = fq.size();
    busy = (wave.size() > 0);
    c    = 3'(n);
    case (a)
      2'd1:    return {30'b0, m_im, m_en};
      2'd2:    return {16'b0, m_div};
      2'd3:    return {25'b0, c, m_ovf, n == 0, n == DEPTH, busy};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    fq.delete();
    wave.delete();
    m_en = 0; m_im = 0; m_ovf = 0; m_div = 16'd15;
  endtask

  // One clock edge of the model, using the pre-edge inputs and state.
  task automatic model_step(input logic r, input logic [1:0] a, input logic w,
                            input logic [31:0] d);
    bit acc;
    logic [7:0] b;
    if (r) begin
      model_reset();
      return;
    end
    acc = w && (a == 2'd0) && (fq.size() < DEPTH);
    if (wave.size() > 0) begin
      void'(wave.pop_front());
    end else if (m_en && fq.size() > 0) begin
      b = fq.pop_front();
      for (int k = 0; k <= int'(m_div); k++) wave.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k <= int'(m_div); k++) wave.push_back(b[i]);
      for (int k = 0; k <= int'(m_div); k++) wave.push_back(1'b1);
    end
    if (w) begin
      case (a)
        2'd0: if (acc) fq.push_back(d[7:0]); else m_ovf = 1;
        2'd1: begin m_en = d[0]; m_im = d[1]; end
        2'd2: m_div = d[15:0];
        2'd3: if (d[3]) m_ovf = 0;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle, check outputs before the edge, then advance the model.
  task automatic cyc(input logic r, input logic [1:0] a, input logic w,
                     input logic [31:0] d);
    reset = r; PrAddr = a; Wr_en = w; Data_in = d;
    @(negedge clk);
    chk("txd", {31'b0, txd}, {31'b0, exp_txd()});
    chk("irq", {31'b0, IRQ}, {31'b0, m_im && fq.size() == 0 && wave.size() == 0});
    chk($sformatf("rd%0d", a), Data_out, exp_read(a));
    @(posedge clk);
    model_step(r, a, w, d);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  a;
    int          op;
    reset = 1'b1; PrAddr = 2'd0; Wr_en = 1'b0; Data_in = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // reset state
    PrAddr = 2'd3; #1;
    chk("rst_status", Data_out, 32'h4);
    PrAddr = 2'd2; #1;
    chk("rst_div", Data_out, 32'd15);
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);

    // single 0xA5 frame at DIV=3
    cyc(0, 2'd2, 1, 32'd3);
    cyc(0, 2'd1, 1, 32'd1);
    cyc(0, 2'd0, 1, 32'hA5);
    idle(50, 2'd3);

    // overflow with EN=0
    cyc(0, 2'd1, 1, 32'd0);
    for (int i = 1; i <= 5; i++) cyc(0, 2'd0, 1, 32'(i));
    cyc(0, 2'd3, 0, 32'd0);
    chk("ovf_status", Data_out, 32'h4A);
    cyc(0, 2'd3, 1, 32'h8);
    chk("ovf_clear", Data_out, 32'h42);

    // IRQ with IM=1 while draining, then IM=0
    cyc(0, 2'd1, 1, 32'd3);
    idle(200, 2'd3);
    chk("irq_idle", {31'b0, IRQ}, 32'd1);
    cyc(0, 2'd1, 1, 32'd1);
    idle(5, 2'd1);

    // back-to-back DIV=0 frames
    cyc(0, 2'd1, 1, 32'd0);
    cyc(0, 2'd2, 1, 32'd0);
    cyc(0, 2'd0, 1, 32'h3C);
    cyc(0, 2'd0, 1, 32'hC3);
    cyc(0, 2'd1, 1, 32'd1);
    idle(30, 2'd3);

    // EN cleared mid-frame
    cyc(0, 2'd2, 1, 32'd3);
    cyc(0, 2'd1, 1, 32'd0);
    cyc(0, 2'd0, 1, 32'h5A);
    cyc(0, 2'd0, 1, 32'h99);
    cyc(0, 2'd1, 1, 32'd1);
    idle(15, 2'd3);
    cyc(0, 2'd1, 1, 32'd0);
    idle(60, 2'd3);
    chk("en_off_status", Data_out, 32'h10);

    // reset mid-DATA
    cyc(0, 2'd1, 1, 32'd1);
    idle(10, 2'd3);
    cyc(1, 2'd3, 0, 32'd0);
    chk("midrst_status", Data_out, 32'h4);
    chk("midrst_txd", {31'b0, txd}, 32'd1);
    chk("midrst_irq", {31'b0, IRQ}, 32'd0);
    PrAddr = 2'd2; #1;
    chk("midrst_div", Data_out, 32'd15);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 19);
      d  = $urandom;
      a  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) cyc(1, a, 0, d);
      else case (op)
        0, 1, 2: cyc(0, 2'd0, 1, d);
        3: begin
          d[0] = ($urandom_range(0, 3) != 0);
          cyc(0, 2'd1, 1, d);
        end
        4: begin
          d[15:0] = 16'($urandom_range(0, 3));
          cyc(0, 2'd2, 1, d);
        end
        5: cyc(0, 2'd3, 1, d);
        default: cyc(0, a, 0, d);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_dev.md
UART_TX_DEV -- requirements
Module: uart_tx_dev

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DIV_RESET, default 16'd15, meaning the reset value of the DIV register.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PrAddr  input  2  register select from the bridge (DEV_ADDR[3:2]).
REQ-006 SHALL have port Wr_en  input  1  register write strobe from the bridge (DEV_WEn).
REQ-007 SHALL have port Data_in  input  32  write data from the bridge (DEV_WD).
REQ-008 SHALL have port Data_out  output  32  read data to the bridge (DEV_RDn); combinational from PrAddr.
REQ-009 SHALL have port IRQ  output  1  level interrupt to a CPU HWInt bit.
REQ-010 SHALL have port txd  output  1  serial line; idle high.

Function
REQ-011 SHALL decode register map on PrAddr: 0 TXDATA, 1 CTRL, 2 DIV, 3 STATUS.
REQ-012 SHALL, on a TXDATA write, push Data_in[7:0] if count < FIFO_DEPTH before the edge; otherwise drop it and set sticky OVF.
REQ-013 SHALL hold CTRL as bit0 EN (transmit enable) and bit1 IM (IRQ mask); writes load Data_in[1:0]; reads return {30'b0, IM, EN}.
REQ-014 SHALL hold DIV as 16 bits; writes load Data_in[15:0]; reads return {16'b0, DIV}; bit period = DIV+1 clk cycles.
REQ-015 SHALL read STATUS as {25'b0, count[2:0] at bits 6:4, OVF bit3, EMPTY bit2, FULL bit1, BUSY bit0}; a STATUS write with Data_in[3]=1 clears OVF; other bits are read-only.
REQ-016 SHALL read TXDATA as 32'b0.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP; BUSY = (state != IDLE).
REQ-018 SHALL, in IDLE with EN=1 and FIFO not empty, pop the head byte into the shift register, latch DIV into a frame divisor, and enter START on that edge.
REQ-019 SHALL drive txd=0 in START, shift-register LSB in DATA, 1 in STOP and IDLE.
REQ-020 SHALL hold each state/bit for exactly latched-DIV+1 cycles; DATA sends 8 bits LSB first; STOP lasts one bit period, then returns to IDLE.
REQ-021 SHALL, therefore, produce frames of 10*(DIV+1) cycles, separated by at least one IDLE cycle when back-to-back.
REQ-022 SHALL leave count unchanged on a same-cycle accepted push and pop; when full, a push SHALL be dropped even if a pop occurs the same cycle.
REQ-023 SHALL finish an in-progress frame when EN is cleared mid-frame and start no further frame.
REQ-024 SHALL not alter the in-progress frame on a DIV write; the new value applies from the next pop.
REQ-025 SHALL drive IRQ = IM & EMPTY & ~BUSY, combinationally from registered state.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, on reset high at a clk edge, set: state IDLE, txd=1, FIFO empty (count 0), OVF=0, CTRL=0, DIV=DIV_RESET, IRQ=0.
REQ-028 SHALL abort any frame in progress on reset mid-frame: txd=1 from the next edge, FIFO contents discarded.

Verification
REQ-029 SHALL cover: DIV=3, EN=1, write TXDATA 0xA5 -> txd = 0 then 1,0,1,0,0,1,0,1 then 1, each for 4 cycles; 40-cycle frame; BUSY falls after it.
REQ-030 SHALL cover: EN=0, five TXDATA writes (0x01..0x05) -> STATUS count=4, FULL=1, OVF=1; write STATUS 0x8 -> OVF=0.
REQ-031 SHALL cover: IM=1, EN=1, one byte queued -> IRQ=0 while BUSY, IRQ=1 on the first cycle after STOP ends; IM=0 -> IRQ=0.
REQ-032 SHALL cover: two bytes queued, DIV=0 -> two 10-cycle frames with exactly one IDLE cycle between.
REQ-033 SHALL cover: clear EN during DATA of frame 1 with 2 bytes queued -> frame 1 completes; txd stays 1; count=1.
REQ-034 SHALL cover: reset asserted mid-DATA -> next edge txd=1, STATUS=0x04, DIV=15, IRQ=0.
